// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned NBYTES = WORD_W / BYTE_W;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Address bits [IO_BIT:IO_BIT-1] equal to this select IO space.
    localparam logic [1:0] IO_SPACE = 2'b11;
    // Low bits of a 32-bit (non-compressed) instruction.
    localparam logic [1:0] INSN_FULL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        IF_RD,
        LS_RD,
        LS_WR
    } state_t;

    // Index of the final byte beat for an LSB access size.
    function automatic logic [1:0] last_beat(input logic [1:0] size);
        case (size)
            SIZE_B:  return 2'd0;
            SIZE_H:  return 2'd1;
            SIZE_W:  return 2'd3;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO bus controller arbitrating the fetch stage and the
// load/store buffer; assembles little-endian words from 1, 2 or 4 beats.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned IO_BIT = 17
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clear,

    input  logic [BYTE_W-1:0]   mem_din,
    input  logic                io_buffer_full,
    output logic [BYTE_W-1:0]   mem_dout,
    output logic [WORD_W-1:0]   mem_a,
    output logic                mem_wr,

    input  logic                if_req,
    input  logic [WORD_W-1:0]   if_addr,
    output logic                if_done,
    output logic [WORD_W-1:0]   if_data,

    input  logic                lsb_req,
    input  logic                lsb_wr,
    input  logic [WORD_W-1:0]   lsb_addr,
    input  logic [1:0]          lsb_size,
    input  logic [WORD_W-1:0]   lsb_wdata,
    output logic                lsb_done,
    output logic [WORD_W-1:0]   lsb_rdata
);

    state_t                         state;
    logic [1:0]                     cnt;
    logic [1:0]                     last;
    logic                           started;
    logic                           wr_q;
    logic [NBYTES-1:0][BYTE_W-1:0]  rbuf;
    logic [NBYTES-1:0][BYTE_W-1:0]  wbuf;
    logic [NBYTES-1:0][BYTE_W-1:0]  assembled;

    logic is_io_c;
    logic io_stall_c;
    logic rvc_now_c;
    logic rvc_done_c;
    logic finish_c;
    logic adv_c;

    // Completed read word including the byte arriving on this edge.
    always_comb begin
        assembled      = rbuf;
        assembled[cnt] = mem_din;
    end

    assign is_io_c    = (mem_a[IO_BIT -: 2] == IO_SPACE);
    assign io_stall_c = (state == LS_WR) && is_io_c && io_buffer_full;
    // A full IO buffer must never see a write strobe, so the gate is immediate.
    assign mem_wr     = wr_q && !io_stall_c;

    // Byte 0 of a fetch is visible on mem_din at the first capture edge,
    // which is early enough to avoid issuing a third address.
    assign rvc_now_c  = (state == IF_RD) && (cnt == 2'd0) && (mem_din[1:0] != INSN_FULL);
    assign rvc_done_c = (state == IF_RD) && (cnt == 2'd1) && (rbuf[0][1:0] != INSN_FULL);
    assign finish_c   = started && ((cnt == last) || rvc_done_c);
    assign adv_c      = started ? (((3'(cnt) + 3'd2) <= 3'(last)) && !rvc_now_c)
                                : (last != 2'd0);

    // Arbitration, beat sequencing and registered completion.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= '0;
            started   <= 1'b0;
            wr_q      <= 1'b0;
            rbuf      <= '0;
            wbuf      <= '0;
            mem_a     <= '0;
            mem_dout  <= '0;
            if_done   <= 1'b0;
            lsb_done  <= 1'b0;
            if_data   <= '0;
            lsb_rdata <= '0;
        end else if (rdy_in) begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!clear && !if_done && !lsb_done && (lsb_req || if_req)) begin
                        cnt     <= '0;
                        started <= 1'b0;
                        rbuf    <= '0;
                        if (lsb_req) begin
                            mem_a <= lsb_addr;
                            last  <= last_beat(lsb_size);
                            wr_q  <= lsb_wr;
                            if (lsb_wr) begin
                                wbuf     <= lsb_wdata;
                                mem_dout <= lsb_wdata[BYTE_W-1:0];
                                state    <= LS_WR;
                            end else begin
                                state    <= LS_RD;
                            end
                        end else begin
                            mem_a <= if_addr;
                            last  <= 2'd3;
                            wr_q  <= 1'b0;
                            state <= IF_RD;
                        end
                    end
                end

                IF_RD, LS_RD: begin
                    if (clear) begin
                        state <= IDLE;
                        wr_q  <= 1'b0;
                    end else begin
                        started <= 1'b1;
                        if (started) begin
                            rbuf[cnt] <= mem_din;
                        end
                        if (finish_c) begin
                            state <= IDLE;
                            if (state == IF_RD) begin
                                if_done <= 1'b1;
                                if_data <= assembled;
                            end else begin
                                lsb_done  <= 1'b1;
                                lsb_rdata <= assembled;
                            end
                        end else begin
                            if (started) begin
                                cnt <= cnt + 2'd1;
                            end
                            if (adv_c) begin
                                mem_a <= mem_a + 32'd1;
                            end
                        end
                    end
                end

                // Stores are committed, so clear does not interrupt them.
                LS_WR: begin
                    if (!io_stall_c) begin
                        if (cnt == last) begin
                            state    <= IDLE;
                            wr_q     <= 1'b0;
                            lsb_done <= 1'b1;
                        end else begin
                            cnt      <= cnt + 2'd1;
                            mem_a    <= mem_a + 32'd1;
                            mem_dout <= wbuf[cnt + 2'd1];
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    wr_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random traffic
// checked against an expected-memory image and per-access latency rules.
module tb_mem_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic [7:0]  mem_din;
    logic        io_full;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req;
    logic        lsb_wr;
    logic [31:0] lsb_addr;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    int passed = 0;
    int total  = 0;
    int wr_cnt = 0;
    int bad_wr = 0;

    logic [7:0] ram     [0:65535];
    logic [7:0] ref_mem [0:65535];

    mem_ctrl #(.IO_BIT(17)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clear),
        .mem_din(mem_din), .io_buffer_full(io_full),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
    );

    always #5 clk = ~clk;

    // RAM with a registered read port, frozen together with the core.
    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
            mem_din <= ram[mem_a[15:0]];
        end
    end

    always @(negedge clk) begin
        if (!rst && rdy && mem_wr) begin
            wr_cnt++;
            if (io_full && mem_a[17:16] == 2'b11) bad_wr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One transaction: clr_at = -1 raises clear in the request cycle, -99 never.
    task automatic run_txn(input bit use_if, input bit wr, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] wdata,
                           input int full_mode, input int clr_at, input int freeze_at,
                           input bit hold_done, input string tag);
        int          n;
        int          stalls;
        int          cyc;
        int          lat;
        logic [31:0] exp_data;
        logic [31:0] off;
        logic [31:0] max_off;
        logic [7:0]  b0;
        logic [15:0] a;
        bit          seen;
        bit          io;
        io = (addr[17:16] == 2'b11);
        if (use_if) begin
            b0 = ref_mem[addr[15:0]];
            n  = (b0[1:0] == 2'b11) ? 4 : 2;
        end else begin
            n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        end
        exp_data = '0;
        for (int i = 0; i < n; i++) begin
            a = 16'(addr + 32'(i));
            if (wr) ref_mem[a] = wdata[8*i +: 8];
            exp_data[8*i +: 8] = ref_mem[a];
        end
        wr_cnt = 0;
        bad_wr = 0;
        if (use_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            lsb_req = 1'b1; lsb_wr = wr; lsb_addr = addr; lsb_size = size; lsb_wdata = wdata;
        end
        clear   = (clr_at == -1);
        stalls  = 0;
        cyc     = 0;
        max_off = '0;
        seen    = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (!(clr_at == -1 && k == 0)) begin
                off = mem_a - addr;
                if (off > max_off) max_off = off;
            end
            seen = use_if ? if_done : lsb_done;
            if (!seen) begin
                clear   = (k == clr_at);
                rdy     = !(freeze_at >= 0 && k >= freeze_at && k < freeze_at + 3);
                io_full = (full_mode == 1) ? 1'($urandom_range(0, 1)) : (full_mode == 2 && k < 3);
                if (wr && io && io_full) stalls++;
            end
        end
        clear   = 1'b0;
        io_full = 1'b0;
        rdy     = 1'b1;
        lat = (wr ? n + stalls : n + 1) + (clr_at == -1 ? 1 : 0) + (freeze_at >= 0 ? 3 : 0);
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, 32'(cyc), 32'(lat + 1));
        if (!wr) check({tag, "_data"}, use_if ? if_data : lsb_rdata, exp_data);
        check({tag, "_span"}, max_off, 32'(n - 1));
        if (wr) begin
            check({tag, "_wrcnt"}, 32'(wr_cnt), 32'(n));
            check({tag, "_wrfull"}, 32'(bad_wr), 32'd0);
        end
        if (use_if) if_req = 1'b0;
        else lsb_req = 1'b0;
        if (hold_done) begin
            rdy = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check({tag, "_hold"}, 32'(use_if ? if_done : lsb_done), 32'd1);
            rdy = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(use_if ? if_done : lsb_done), 32'd0);
    endtask

    int          cyc;
    int          ndone;
    int          nwr;
    bit          seen;
    bit          if_early;
    logic [31:0] ra;
    logic [7:0]  rb;

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_full = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsb_req = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_size = '0; lsb_wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            rb = 8'($urandom);
            ram[i] = rb;
            ref_mem[i] = rb;
        end
        ram[16'h1000] = 8'h93; ram[16'h1001] = 8'h00; ram[16'h1002] = 8'hA0; ram[16'h1003] = 8'h00;
        ram[16'h2002] = 8'h01; ram[16'h2003] = 8'h45;
        ram[16'h3000] = 8'hEF; ram[16'h3001] = 8'hBE; ram[16'h3002] = 8'hAD; ram[16'h3003] = 8'hDE;
        for (int i = 0; i < 4; i++) begin
            ref_mem[16'h1000 + 16'(i)] = ram[16'h1000 + 16'(i)];
            ref_mem[16'h2002 + 16'(i)] = ram[16'h2002 + 16'(i)];
            ref_mem[16'h3000 + 16'(i)] = ram[16'h3000 + 16'(i)];
        end

        #12;
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_dout", 32'(mem_dout), 32'd0);
        check("rst_done", 32'({if_done, lsb_done}), 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_lsb_rdata", lsb_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_txn(1'b1, 1'b0, 32'h0000_1000, SIZE_W, 32'd0, 0, -99, -1, 1'b0, "fetch_w");
        check("fetch_w_val", if_data, 32'h00A0_0093);
        run_txn(1'b1, 1'b0, 32'h0000_2002, SIZE_W, 32'd0, 0, -99, -1, 1'b0, "fetch_c");
        check("fetch_c_val", if_data, 32'h0000_4501);

        // Both requesters at once: the LSB goes first, the fetch waits.
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h3000; lsb_size = SIZE_W;
        if_req = 1'b1; if_addr = 32'h1000;
        cyc = 0; seen = 1'b0; if_early = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(posedge clk); #1;
            cyc++;
            seen = lsb_done;
            if (if_done) if_early = 1'b1;
        end
        check("arb_lsb_lat", 32'(cyc), 32'd6);
        check("arb_lsb_data", lsb_rdata, 32'hDEAD_BEEF);
        check("arb_if_waits", 32'(if_early), 32'd0);
        lsb_req = 1'b0;
        cyc = 0; seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(posedge clk); #1;
            cyc++;
            seen = if_done;
        end
        check("arb_if_lat", 32'(cyc), 32'd7);
        check("arb_if_data", if_data, 32'h00A0_0093);
        if_req = 1'b0;
        @(posedge clk); #1;

        run_txn(1'b0, 1'b1, 32'h0003_0000, SIZE_B, 32'h0000_0041, 2, -99, -1, 1'b0, "io_st");
        check("io_st_byte", 32'(ram[16'h0000]), 32'h41);

        // Squash a fetch at the first capture edge.
        if_req = 1'b1; if_addr = 32'h1000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b1; if_req = 1'b0;
        @(posedge clk); #1;
        clear = 1'b0;
        ndone = 0; nwr = 0;
        repeat (8) begin
            if (if_done || lsb_done) ndone++;
            if (mem_wr) nwr++;
            @(posedge clk); #1;
        end
        check("clr_if_done", 32'(ndone), 32'd0);
        check("clr_if_wr", 32'(nwr), 32'd0);

        run_txn(1'b0, 1'b1, 32'h0000_5000, SIZE_W, 32'hCAFE_F00D, 0, 1, -1, 1'b0, "st_clr");
        check("st_clr_mem", {ram[16'h5003], ram[16'h5002], ram[16'h5001], ram[16'h5000]}, 32'hCAFE_F00D);
        run_txn(1'b0, 1'b0, 32'h0000_5001, SIZE_B, 32'd0, 0, -1, -1, 1'b0, "ld_clrblk");
        run_txn(1'b0, 1'b0, 32'hFFFF_FFFF, SIZE_W, 32'd0, 0, -99, -1, 1'b0, "ld_wrap");
        run_txn(1'b0, 1'b0, 32'h0000_5000, SIZE_W, 32'd0, 0, -99, 1, 1'b1, "ld_frz");

        // Asynchronous reset in the middle of a word load.
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h4000; lsb_size = SIZE_W;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstm_mem_a", mem_a, 32'd0);
        check("rstm_mem_dout", 32'(mem_dout), 32'd0);
        check("rstm_if_data", if_data, 32'd0);
        check("rstm_lsb_rdata", lsb_rdata, 32'd0);
        lsb_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_txn(1'b0, 1'b0, 32'h0000_4000, SIZE_W, 32'd0, 0, -99, -1, 1'b0, "after_rst");

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 2))
                0: begin
                    ra = 32'($urandom_range(0, 32'h1FFFF));
                    run_txn(1'b1, 1'b0, ra, SIZE_W, 32'd0, 0, -99, -1, 1'b0, "rnd_fetch");
                end
                1: begin
                    ra = ($urandom_range(0, 3) == 0) ? 32'h0003_0000 + 32'($urandom_range(0, 16'hFFF0))
                                                    : 32'($urandom_range(0, 32'h1FFF0));
                    run_txn(1'b0, 1'b0, ra, 2'($urandom_range(0, 2)), 32'd0, 0, -99, -1, 1'b0, "rnd_load");
                end
                default: begin
                    ra = ($urandom_range(0, 1) == 0) ? 32'h0003_0000 + 32'($urandom_range(0, 16'hFFF0))
                                                    : 32'($urandom_range(0, 32'h1FFF0));
                    run_txn(1'b0, 1'b1, ra, 2'($urandom_range(0, 2)), $urandom, 1, -99, -1, 1'b0, "rnd_store");
                end
            endcase
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
